// File: rtl/answer_judge_fsm.sv
// Answer judge for the factorisation game: captures a submitted answer, compares it
// digit-by-digit with the question record, and reports correct/wrong/locked-out.
module answer_judge_fsm #(
  parameter int DIGITS      = 3,
  parameter int DIGIT_W     = 4,
  parameter int QUEST_W     = 24,
  parameter int MAX_TRIES   = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             SUBMIT,
  input  logic                             NEW_Q,
  input  logic [DIGITS*DIGIT_W-1:0]        ANSWER,
  input  logic [QUEST_W-1:0]               QUESTION,
  output logic [1:0]                       RESULT,
  output logic                             RESULT_VALID,
  output logic [DIGITS-1:0]                DIGIT_MATCH,
  output logic [$clog2(MAX_TRIES+1)-1:0]   TRIES,
  output logic                             BUSY
);

  localparam int ANS_W   = DIGITS * DIGIT_W;
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_CORRECT = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b11;
  localparam logic [1:0] RES_LOCKED  = 2'b10;

  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, SHOW, LOCK} state_t;

  state_t             state;
  logic [ANS_W-1:0]   ans_cap;
  logic [ANS_W-1:0]   q_cap;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [DIGITS-1:0]  match;
  logic [TRIES_W-1:0] tries_inc;

  // Question bits above the compared digits carry no meaning for the judge.
  if (QUEST_W > ANS_W) begin : g_q_upper
    logic unused_q_upper;
    assign unused_q_upper = ^QUESTION[QUEST_W-1:ANS_W];
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < DIGITS; i++) begin
      match[i] = (ans_cap[i*DIGIT_W +: DIGIT_W] == q_cap[i*DIGIT_W +: DIGIT_W]);
    end
  end

  assign tries_inc = TRIES + TRIES_W'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      RESULT       <= RES_NONE;
      RESULT_VALID <= 1'b0;
      DIGIT_MATCH  <= '0;
      TRIES        <= '0;
      BUSY         <= 1'b0;
      hold_cnt     <= '0;
      ans_cap      <= '0;
      q_cap        <= '0;
    end else begin
      RESULT_VALID <= 1'b0;
      // A new question aborts whatever is in flight, including a same-cycle submit.
      if (NEW_Q) begin
        state       <= IDLE;
        RESULT      <= RES_NONE;
        DIGIT_MATCH <= '0;
        TRIES       <= '0;
        BUSY        <= 1'b0;
        hold_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (SUBMIT && (ANSWER != '0)) begin
              ans_cap <= ANSWER;
              q_cap   <= QUESTION[ANS_W-1:0];
              state   <= COMPARE;
              BUSY    <= 1'b1;
            end
          end
          COMPARE: begin
            DIGIT_MATCH  <= match;
            RESULT_VALID <= 1'b1;
            hold_cnt     <= '0;
            if (&match) begin
              RESULT <= RES_CORRECT;
              state  <= SHOW;
            end else begin
              TRIES <= tries_inc;
              if (tries_inc == TRIES_MAX) begin
                RESULT <= RES_LOCKED;
                state  <= LOCK;
              end else begin
                RESULT <= RES_WRONG;
                state  <= SHOW;
              end
            end
          end
          SHOW: begin
            if (hold_cnt == HOLD_LAST) begin
              RESULT <= RES_NONE;
              state  <= IDLE;
              BUSY   <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          LOCK: begin
            state <= LOCK;
          end
          default: begin
            state  <= IDLE;
            RESULT <= RES_NONE;
            BUSY   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
